req_arbiter8: RTL and testbench

//  Sequential 8-requester arbiter for one shared resource (bus, datapath slot, output port).

---
 rtl/arb_pkg.sv | 33 +++
 rtl/priority_encoder8_3.sv | 21 ++
 rtl/req_arbiter8.sv | 152 +++++++++++++++
 tb/tb_req_arbiter8.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and sizes for the 8-way request arbiter.
// Holds the FSM encoding and small mask/one-hot helpers.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;
  localparam int CNT_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Bits strictly below id: (1 << id) - 1
  function automatic logic [N_REQ-1:0] below_mask(
    input logic [ID_W-1:0] id
  );
    logic [N_REQ-1:0] one;
    one = N_REQ'(1);
    below_mask = (one << id) - one;
  endfunction

  // One-hot vector of id when v is set, zero otherwise
  function automatic logic [N_REQ-1:0] onehot(
    input logic            v,
    input logic [ID_W-1:0] id
  );
    logic [N_REQ-1:0] one;
    one = N_REQ'(v);
    onehot = one << id;
  endfunction

endpackage

// File: rtl/priority_encoder8_3.sv
// 8-to-3 priority encoder, bit 7 has highest priority.
// o_out is only meaningful while o_valid is high.
module priority_encoder8_3 (
  input  logic [7:0] i_in,
  output logic [2:0] o_out,
  output logic       o_valid
);

  // Scan upward so the highest set bit is the last one written
  always_comb begin
    o_out   = 3'd0;
    o_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i_in[i]) begin
        o_out   = 3'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_arbiter8.sv
// Sequential 8-requester arbiter, fixed priority or round-robin.
// Grant is held until release, request drop or hold timeout.
module req_arbiter8
  import arb_pkg::*;
#(
  parameter logic        RR_MODE  = 1'b0,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_release,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_grant_id,
  output logic             o_grant_valid,
  output logic             o_timeout
);

  arb_state_e       r_state;
  logic [N_REQ-1:0] r_grant;
  logic [ID_W-1:0]  r_grant_id;
  logic             r_grant_valid;
  logic             r_timeout;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [ID_W-1:0]  r_last_id;
  logic             r_first;

  arb_state_e       w_state_n;
  logic [ID_W-1:0]  w_id_n;
  logic             w_valid_n;
  logic             w_to_n;
  logic [CNT_W-1:0] w_cnt_n;
  logic [ID_W-1:0]  w_last_n;
  logic             w_first_n;

  logic [N_REQ-1:0] w_mask;
  logic [N_REQ-1:0] w_masked;
  logic [ID_W-1:0]  w_req_id;
  logic             w_req_v;
  logic [ID_W-1:0]  w_msk_id;
  logic             w_msk_v;
  logic [ID_W-1:0]  w_win_id;

  logic             w_rel;
  logic             w_drop;
  logic             w_hit;
  logic             w_exit;
  logic             w_to_only;

  // Until the first grant ends, every index is eligible so
  // the rotation starts at 7 rather than 6.
  assign w_mask   = r_first ? '1 : below_mask(r_last_id);
  assign w_masked = i_req & w_mask;

  priority_encoder8_3 u_enc_req (
    .i_in    (i_req),
    .o_out   (w_req_id),
    .o_valid (w_req_v)
  );

  priority_encoder8_3 u_enc_msk (
    .i_in    (w_masked),
    .o_out   (w_msk_id),
    .o_valid (w_msk_v)
  );

  // Policy mux; encoder outputs are only used when valid
  always_comb begin
    w_win_id = '0;
    if (RR_MODE && w_msk_v) begin
      w_win_id = w_msk_id;
    end else if (w_req_v) begin
      w_win_id = w_req_id;
    end
  end

  assign w_rel     = i_release;
  assign w_drop    = ~i_req[r_grant_id];
  assign w_hit     = (MAX_HOLD != 0) &&
                     (r_hold_cnt == CNT_W'(MAX_HOLD));
  assign w_exit    = w_rel | w_drop | w_hit;
  assign w_to_only = w_hit & ~w_rel & ~w_drop;

  // Next-state and next-output logic
  always_comb begin
    w_state_n = r_state;
    w_id_n    = r_grant_id;
    w_valid_n = r_grant_valid;
    w_to_n    = 1'b0;
    w_cnt_n   = r_hold_cnt;
    w_last_n  = r_last_id;
    w_first_n = r_first;
    unique case (r_state)
      ST_IDLE: begin
        w_id_n    = '0;
        w_valid_n = 1'b0;
        w_cnt_n   = '0;
        if (w_req_v) begin
          w_state_n = ST_GRANT;
          w_id_n    = w_win_id;
          w_valid_n = 1'b1;
          w_cnt_n   = CNT_W'(1);
        end
      end
      ST_GRANT: begin
        if (w_exit) begin
          w_state_n = ST_IDLE;
          w_id_n    = '0;
          w_valid_n = 1'b0;
          w_cnt_n   = '0;
          w_to_n    = w_to_only;
          w_last_n  = r_grant_id;
          w_first_n = 1'b0;
        end else if (r_hold_cnt != '1) begin
          w_cnt_n = r_hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
      r_hold_cnt    <= '0;
      r_last_id     <= ID_W'(N_REQ - 1);
      r_first       <= 1'b1;
    end else begin
      r_state       <= w_state_n;
      r_grant       <= onehot(w_valid_n, w_id_n);
      r_grant_id    <= w_id_n;
      r_grant_valid <= w_valid_n;
      r_timeout     <= w_to_n;
      r_hold_cnt    <= w_cnt_n;
      r_last_id     <= w_last_n;
      r_first       <= w_first_n;
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_id    = r_grant_id;
  assign o_grant_valid = r_grant_valid;
  assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_req_arbiter8.sv
// Directed bench for req_arbiter8 in three configurations:
// fixed priority, round-robin without timeout, fixed with MAX_HOLD=4.
module tb_req_arbiter8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       fp_rst = 1'b1, rr_rst = 1'b1, to_rst = 1'b1;
  logic [7:0] fp_req = '0,   rr_req = '0,   to_req = '0;
  logic       fp_rel = 1'b0, rr_rel = 1'b0, to_rel = 1'b0;
  logic [7:0] fp_g, rr_g, to_g;
  logic [2:0] fp_id, rr_id, to_id;
  logic       fp_v, rr_v, to_v;
  logic       fp_to, rr_to, to_to;

  req_arbiter8 #(.RR_MODE(1'b0), .MAX_HOLD(16)) u_fp (
    .i_clk(clk), .i_rst(fp_rst), .i_req(fp_req),
    .i_release(fp_rel), .o_grant(fp_g), .o_grant_id(fp_id),
    .o_grant_valid(fp_v), .o_timeout(fp_to)
  );

  req_arbiter8 #(.RR_MODE(1'b1), .MAX_HOLD(0)) u_rr (
    .i_clk(clk), .i_rst(rr_rst), .i_req(rr_req),
    .i_release(rr_rel), .o_grant(rr_g), .o_grant_id(rr_id),
    .o_grant_valid(rr_v), .o_timeout(rr_to)
  );

  req_arbiter8 #(.RR_MODE(1'b0), .MAX_HOLD(4)) u_to (
    .i_clk(clk), .i_rst(to_rst), .i_req(to_req),
    .i_release(to_rel), .o_grant(to_g), .o_grant_id(to_id),
    .o_grant_valid(to_v), .o_timeout(to_to)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // grant must always equal valid << id (hence one-hot or zero)
  always @(negedge clk) begin
    chk("oh_fp", fp_g, 32'(8'(fp_v) << fp_id));
    chk("oh_rr", rr_g, 32'(8'(rr_v) << rr_id));
    chk("oh_to", to_g, 32'(8'(to_v) << to_id));
  end

  int rr_seq [13] = '{7, 6, 5, 4, 3, 2, 1, 0, 7, 6, 5, 4, 3};

  initial begin
    // T1 reset with all requests high
    fp_req = 8'hFF;
    tick();
    tick();
    chk("t1_rst_g", fp_g, 8'h00);
    chk("t1_rst_v", fp_v, 0);
    chk("t1_rst_to", fp_to, 0);
    fp_rst = 1'b0;
    tick();
    chk("t1_g", fp_g, 8'h80);
    chk("t1_id", fp_id, 7);
    fp_req = 8'h00;
    tick();
    chk("t1_drop_v", fp_v, 0);

    // T2 fixed priority
    fp_req = 8'b0010_0100;
    tick();
    chk("t2_id5", fp_id, 5);
    chk("t2_g5", fp_g, 8'h20);
    fp_rel = 1'b1;
    tick();
    chk("t2_gap_v", fp_v, 0);
    chk("t2_gap_to", fp_to, 0);
    fp_rel = 1'b0;
    tick();
    chk("t2_regrant", fp_id, 5);
    chk("t2_regrant_v", fp_v, 1);
    fp_req = 8'b0000_0100;
    tick();
    chk("t2_drop5_v", fp_v, 0);
    tick();
    chk("t2_id2", fp_id, 2);
    chk("t2_g2", fp_g, 8'h04);
    fp_req = 8'h00;
    tick();

    // T5 request drop hands over after one idle cycle
    fp_req = 8'h40;
    tick();
    chk("t5_id6", fp_id, 6);
    fp_req = 8'h02;
    tick();
    chk("t5_drop_v", fp_v, 0);
    chk("t5_drop_to", fp_to, 0);
    tick();
    chk("t5_id1", fp_id, 1);
    chk("t5_v1", fp_v, 1);
    fp_req = 8'h00;
    tick();

    // T3 round-robin
    rr_rst = 1'b0;
    rr_req = 8'hFF;
    foreach (rr_seq[k]) begin
      tick();
      chk($sformatf("t3_id%0d", k), rr_id, rr_seq[k]);
      chk($sformatf("t3_v%0d", k), rr_v, 1);
      rr_rel = 1'b1;
      tick();
      chk($sformatf("t3_gap%0d", k), rr_v, 0);
      rr_rel = 1'b0;
    end
    rr_req = 8'b0000_1001;
    tick();
    chk("t3_wrap0", rr_id, 0);
    rr_rel = 1'b1;
    tick();
    chk("t3_wrap_gap", rr_v, 0);
    rr_rel = 1'b0;
    tick();
    chk("t3_wrap3", rr_id, 3);
    rr_rel = 1'b1;
    tick();
    rr_rel = 1'b0;

    // T6 reset mid-grant with hold count 3
    rr_req = 8'hFF;
    tick();
    chk("t6_id2", rr_id, 2);
    tick();
    tick();
    chk("t6_hold_v", rr_v, 1);
    rr_rst = 1'b1;
    tick();
    chk("t6_rst_g", rr_g, 8'h00);
    chk("t6_rst_v", rr_v, 0);
    chk("t6_rst_to", rr_to, 0);
    rr_rst = 1'b0;
    tick();
    chk("t6_restart7", rr_id, 7);
    rr_req = 8'h00;
    tick();

    // T4 hold timeout
    to_rst = 1'b0;
    to_req = 8'h10;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("t4_v_c%0d", c), to_v, 1);
      chk($sformatf("t4_to_c%0d", c), to_to, 0);
    end
    tick();
    chk("t4_exp_v", to_v, 0);
    chk("t4_exp_to", to_to, 1);
    tick();
    chk("t4_regrant_id", to_id, 4);
    chk("t4_regrant_v", to_v, 1);
    chk("t4_pulse_end", to_to, 0);
    tick();
    tick();
    tick();
    to_rel = 1'b1;
    tick();
    chk("t4_rel_v", to_v, 0);
    chk("t4_rel_to", to_to, 0);
    to_rel = 1'b0;
    to_req = 8'h00;
    tick();
    chk("t4_idle_to", to_to, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
